// File: rtl/audio_pkg.sv
// Shared audio-path constants and the receiver state type.
package audio_pkg;
  localparam logic I2S_LEFT  = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;

  typedef enum logic {SEARCH, RECEIVE} rx_state_t;
endpackage

// File: rtl/i2s_rx_if.sv
// I2S serial inputs plus the parallel stereo sample outputs of the receiver.
interface i2s_rx_if #(parameter int SAMPLE_WIDTH = 16);
  logic                    sclk;
  logic                    lrclk;
  logic                    sdata;
  logic [SAMPLE_WIDTH-1:0] left_chan;
  logic [SAMPLE_WIDTH-1:0] right_chan;
  logic                    sample_valid;
  logic                    short_word;
  logic                    locked;

  modport master (output sclk, lrclk, sdata,
                  input  left_chan, right_chan, sample_valid, short_word, locked);
  modport slave  (input  sclk, lrclk, sdata,
                  output left_chan, right_chan, sample_valid, short_word, locked);
endinterface

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous input bit.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/i2s_rx.sv
// I2S (Philips) slave receiver: samples BCK/LRCK/SDATA in the clk domain and
// emits left/right sample pairs with a one-cycle strobe.
module i2s_rx
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_WIDTH    = 6
) (
  input  logic     clk,
  input  logic     reset,
  i2s_rx_if.slave  bus
);
  logic [2:0] raw, syn;
  logic       sclk_q, rise, lr_now, bit_now, lr_prev;
  rx_state_t  state;

  logic [CNT_WIDTH-1:0]    cnt, cnt_inc;
  logic [SAMPLE_WIDTH-1:0] shreg, word, left_stage;
  logic [SAMPLE_WIDTH-1:0] left_chan, right_chan;
  logic                    left_ok, word_end, last_short;
  logic                    sample_valid, short_word, locked;

  assign raw = {bus.sdata, bus.lrclk, bus.sclk};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (raw[g]),
      .q    (syn[g])
    );
  end

  // Current word with this rise's bit merged in; bits past SAMPLE_WIDTH fall off.
  always_comb begin
    cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    word    = shreg;
    for (int i = 0; i < SAMPLE_WIDTH; i++)
      if (int'(cnt) == SAMPLE_WIDTH - 1 - i) word[i] = bit_now;
    word_end   = (lr_now != lr_prev);
    last_short = (int'(cnt_inc) < SAMPLE_WIDTH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q       <= 1'b0;
      rise         <= 1'b0;
      lr_now       <= 1'b0;
      bit_now      <= 1'b0;
      lr_prev      <= 1'b0;
      state        <= SEARCH;
      cnt          <= '0;
      shreg        <= '0;
      left_stage   <= '0;
      left_ok      <= 1'b0;
      left_chan    <= '0;
      right_chan   <= '0;
      sample_valid <= 1'b0;
      short_word   <= 1'b0;
      locked       <= 1'b0;
    end else begin
      // Strobe and its data are registered together so they stay aligned.
      sclk_q       <= syn[0];
      rise         <= syn[0] & ~sclk_q;
      lr_now       <= syn[1];
      bit_now      <= syn[2];
      sample_valid <= 1'b0;
      short_word   <= 1'b0;

      if (rise) begin
        lr_prev <= lr_now;
        if (state == SEARCH) begin
          if (word_end) begin
            state  <= RECEIVE;
            locked <= 1'b1;
            cnt    <= '0;
            shreg  <= '0;
          end
        end else if (word_end) begin
          cnt        <= '0;
          shreg      <= '0;
          short_word <= last_short;
          if (lr_prev == I2S_LEFT) begin
            left_stage <= word;
            left_ok    <= 1'b1;
          end else if (left_ok) begin
            left_chan    <= left_stage;
            right_chan   <= word;
            sample_valid <= 1'b1;
            left_ok      <= 1'b0;
          end
        end else begin
          shreg <= word;
          cnt   <= cnt_inc;
        end
      end
    end
  end

  assign bus.left_chan    = left_chan;
  assign bus.right_chan   = right_chan;
  assign bus.sample_valid = sample_valid;
  assign bus.short_word   = short_word;
  assign bus.locked       = locked;
endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: directed I2S frames, expected pairs queued at send time.
module tb_i2s_rx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  i2s_rx_if #(.SAMPLE_WIDTH(16)) bus();

  i2s_rx #(.SAMPLE_WIDTH(16), .SYNC_STAGES(2), .CNT_WIDTH(6)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0, checks = 0, shorts = 0, valids = 0;
  logic [31:0] exp_q[$];
  logic dly = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest queued pair.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.short_word) shorts++;
      if (bus.sample_valid) begin
        valids++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_sample: got %h_%h expected none", bus.left_chan, bus.right_chan);
        end else begin
          chk("sample", {bus.left_chan, bus.right_chan}, exp_q.pop_front());
        end
      end
    end
  end

  // One BCK period (8 clk): LRCK/SDATA change with the falling edge.
  task automatic bck_cycle(input logic lr, input logic d);
    bus.sclk = 1'b0; bus.lrclk = lr; bus.sdata = d;
    #40;
    bus.sclk = 1'b1;
    #40;
  endtask

  // Data lags LRCK by one BCK: each cycle carries the previous slot position's bit.
  task automatic send_slot(input logic lr, input logic [31:0] w, input int wbits, input int slot);
    logic cur;
    for (int k = 0; k < slot; k++) begin
      cur = (k < wbits) ? w[wbits-1-k] : 1'b0;
      bck_cycle(lr, dly);
      dly = cur;
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int wbits,
                            input int slot, input bit expect_pair, input logic [31:0] pair);
    if (expect_pair) exp_q.push_back(pair);
    send_slot(1'b0, l, wbits, slot);
    send_slot(1'b1, r, wbits, slot);
  endtask

  task automatic flush();
    bck_cycle(1'b0, dly);
    dly = 1'b0;
    repeat (4) bck_cycle(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.sclk = 1'b0; bus.lrclk = 1'b0; bus.sdata = 1'b0;
    dly = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic end_phase(input string name, input int v0, input int s0,
                           input int nv, input int ns);
    @(negedge clk);
    chk({name, "_valids"}, valids - v0, nv);
    chk({name, "_shorts"}, shorts - s0, ns);
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_locked"}, {31'b0, bus.locked}, 1);
    exp_q.delete();
  endtask

  int v0, s0;

  initial begin
    bus.sclk = 1'b0; bus.lrclk = 1'b0; bus.sdata = 1'b0;

    // Reset held while inputs toggle
    for (int k = 0; k < 6; k++) bck_cycle(k[0], 1'b1);
    @(negedge clk);
    chk("rst_left", {16'b0, bus.left_chan}, 0);
    chk("rst_right", {16'b0, bus.right_chan}, 0);
    chk("rst_flags", {29'b0, bus.sample_valid, bus.short_word, bus.locked}, 0);
    bus.lrclk = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("locked_after_release", {31'b0, bus.locked}, 0);
    send_slot(1'b0, 32'h1111, 16, 16);
    chk("locked_no_edge", {31'b0, bus.locked}, 0);
    send_slot(1'b1, 32'h2222, 16, 16);
    chk("locked_first_edge", {31'b0, bus.locked}, 1);
    chk("no_sample_before_pair", valids, 0);

    // 16-bit words in 16-BCK slots
    do_reset(); v0 = valids; s0 = shorts;
    send_frame(32'h1234, 32'hABCD, 16, 16, 0, 0);
    repeat (3) send_frame(32'h1234, 32'hABCD, 16, 16, 1, 32'h1234_ABCD);
    flush();
    end_phase("w16", v0, s0, 3, 0);

    // 24-bit words, 64 BCK/frame: low bits truncated
    do_reset(); v0 = valids; s0 = shorts;
    send_frame(32'h80_0001, 32'h7F_FFFE, 24, 32, 0, 0);
    repeat (2) send_frame(32'h80_0001, 32'h7F_FFFE, 24, 32, 1, 32'h8000_7FFF);
    flush();
    end_phase("w24", v0, s0, 2, 0);

    // 80-BCK slots: bit counter must saturate, not wrap
    do_reset(); v0 = valids; s0 = shorts;
    send_frame(32'hC3A5, 32'h5AC3, 16, 80, 0, 0);
    send_frame(32'hC3A5, 32'h5AC3, 16, 80, 1, 32'hC3A5_5AC3);
    flush();
    end_phase("sat", v0, s0, 1, 0);

    // 12-bit words in 12-BCK slots: zero-filled and flagged short
    do_reset(); v0 = valids; s0 = shorts;
    send_frame(32'hFFF, 32'h001, 12, 12, 0, 0);
    repeat (2) send_frame(32'hFFF, 32'h001, 12, 12, 1, 32'hFFF0_0010);
    flush();
    end_phase("w12", v0, s0, 2, 5);

    // Stream starts mid right word
    do_reset(); v0 = valids; s0 = shorts;
    send_slot(1'b1, 32'h0F0F, 16, 7);
    repeat (3) send_frame(32'h5A5A, 32'h0F0F, 16, 16, 1, 32'h5A5A_0F0F);
    flush();
    end_phase("midright", v0, s0, 3, 1);

    // Reset asserted mid left word
    do_reset(); v0 = valids;
    send_frame(32'h1357, 32'h2468, 16, 16, 0, 0);
    send_frame(32'h1357, 32'h2468, 16, 16, 1, 32'h1357_2468);
    send_slot(1'b0, 32'h9999, 16, 8);
    chk("pre_reset_valids", valids - v0, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_left", {16'b0, bus.left_chan}, 0);
    chk("midrst_locked", {31'b0, bus.locked}, 0);
    reset = 1'b0;
    v0 = valids; s0 = shorts;
    send_slot(1'b0, 32'h9999, 16, 8);
    chk("midrst_relock", {31'b0, bus.locked}, 0);
    send_slot(1'b1, 32'h7777, 16, 16);
    repeat (2) send_frame(32'h4C4C, 32'h3B3B, 16, 16, 1, 32'h4C4C_3B3B);
    flush();
    end_phase("midrst", v0, s0, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
